word_to_bit_stream_serializer: RTL
==================================

# word_to_bit_stream_serializer

Parallel-to-serial converter that feeds the serial sequence detectors in the FSM exercise set. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `out_bit`, which drives a detector's `new_bit` input directly. A one-word holding buffer lets back-to-back words stream with no gap. When no word is pending, the stream is filled with a fixed idle bit.

## Interface

Parameters:
- `WIDTH`, default 8: word width in bits; legal range is at least 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 1'b0: value driven on `out_bit` when no word is being shifted.

Ports:
- `clk` input, 1 bit: clock; all state updates on posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: `in_data` holds a word to send.
- `in_data` input, WIDTH bits: word to serialize.
- `in_ready` output, 1 bit: block can accept a word this cycle.
- `out_bit` output, 1 bit: serial data; connects to the detector's `new_bit`.
- `out_valid` output, 1 bit: `out_bit` carries a data bit, not idle fill.
- `busy` output, 1 bit: shift register active or holding buffer occupied.

## Operation

- State:
  - shift register `sr[WIDTH-1:0]`
  - bit counter `cnt`, $clog2(WIDTH) bits
  - FSM with two states: IDLE and SHIFT
  - holding buffer `hb[WIDTH-1:0]` with flag `hb_full`
- Handshake:
  - A transfer occurs when `in_valid && in_ready` at a posedge.
  - `in_ready = !hb_full`, combinational from registered state only; it does not depend on `in_valid`.
  - `in_data` is sampled only on a transfer. The sender holds `in_valid` and `in_data` stable until the transfer.
- IDLE: `out_valid`=0, `out_bit`=IDLE_BIT.
  - On a transfer: load `sr` from `in_data`, set `cnt`=0, go to SHIFT.
- SHIFT: `out_valid`=1. `out_bit` = `sr[WIDTH-1]` if MSB_FIRST, otherwise `sr[0]`. Each cycle the sent bit is shifted out and `cnt` increments.
- Last-bit cycle (`cnt`==WIDTH-1), at the next edge, with priority in this order:
  1. `hb_full`: load `sr` from `hb`, clear `hb_full`, `cnt`=0, stay in SHIFT. A same-cycle transfer is impossible because `in_ready`=0.
  2. Transfer this cycle (`hb` empty): load `sr` directly from `in_data` (bypass `hb`), `cnt`=0, stay in SHIFT.
  3. Otherwise: go to IDLE.
- Non-last SHIFT cycle with a transfer: write `hb`, set `hb_full`.
- Counter range: `cnt` counts 0..WIDTH-1 and never wraps past WIDTH-1.
- Reset mid-word: the word in flight and the buffered word are discarded. No partial word is resumed.

## Timing

- Reset values:
  - FSM=IDLE, `hb_full`=0, `cnt`=0, `sr`=0.
  - Outputs: `out_valid`=0, `out_bit`=IDLE_BIT, `in_ready`=1, `busy`=0.
- Latency: a word transferred at edge E (block idle) drives its first bit during the cycle after E. The last bit appears WIDTH-1 cycles later.
- Back-to-back words: the word stream is continuous; `out_valid` stays high for k·WIDTH cycles for k queued words.
- Throughput: one bit per clock, i.e. one word per WIDTH cycles. Sustained `in_valid` sees `in_ready` high once per word after the buffer fills.
- `out_bit` and `out_valid` are functions of registered state only; there is no combinational path from `in_*` to `out_*`.

## Structure

- Package `serializer_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t`
  - helper localparam for the counter width
- Optional sub-module `word_holding_buffer`: one-entry valid/ready register providing `hb` and `hb_full`, with a pop input.
- Top level: the serializer FSM, instantiated upstream of `detect_6_bit_sequence_using_shift_reg`.

## Test plan

- Reset and idle: hold `rst` 2 cycles, then idle 5 cycles. Expect `out_valid`=0, `out_bit`=0, `in_ready`=1 throughout.
- Single word, WIDTH=8, MSB_FIRST=1: send 0xCC. Expect bits 1,1,0,0,1,1,0,0 on cycles E+1..E+8, then idle. A downstream 110011 detector pulses once, at the edge after the sixth bit.
- Back-to-back words: hold `in_valid` with 0xA5 then 0x3C. Expect 16 contiguous valid bits 10100101 00111100, and `in_ready` low while `hb_full`=1.
- Bypass path: present a word exactly in the last-bit cycle with `hb` empty. Expect the next word's bit 7 on the immediately following cycle, with no idle gap.
- LSB-first: MSB_FIRST=0, send 0x01. Expect 1,0,0,0,0,0,0,0.
- Reset mid-word: assert `rst` after 3 bits of 0xFF with 0x00 buffered. Expect IDLE, `out_valid`=0 and `in_ready`=1 on the cycle after reset, and no remaining bits emitted.

Source files
------------

// File: rtl/word_to_bit_stream_serializer_pkg.sv
// Shared types for the word-to-bit-stream serializer.
//   ser_state_t : serializer FSM state (IDLE / SHIFT)
//   cnt_width() : width of the bit counter for a given word width
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Enough bits to count 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/word_to_bit_stream_serializer_if.sv
// Word-in / bit-out bundle of the serializer.
//   in_valid, in_data  : word offered by the sender (sender -> serializer)
//   in_ready           : serializer can take a word this cycle
//   out_bit, out_valid : serial stream and its data/idle qualifier
//   busy               : serializer has a word in flight or buffered
// Modports: master = word sender / stream consumer, slave = serializer.
interface word_to_bit_stream_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_bit, out_valid, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_bit, out_valid, busy
  );

endinterface

// File: rtl/word_to_bit_stream_serializer_buffer.sv
// One-entry holding register that parks the next word while the current
// one is still being shifted out.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : capture data_i and mark the entry full
//   pop_i    : release the entry (its data is consumed the same cycle)
//   data_i   : word to park
//   data_o   : parked word
//   full_o   : entry holds a word
module word_holding_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (rst)         full_q <= 1'b0;
    else if (push_i) full_q <= 1'b1;
    else if (pop_i)  full_q <= 1'b0;
  end

  // NOTE: the data register is deliberately left out of reset; full_q alone
  // decides whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (push_i) data_q <= data_i;
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/word_to_bit_stream_serializer.sv
// Parallel-to-serial converter: accepts WIDTH-bit words over valid/ready and
// emits them one bit per clock, back-to-back words without a gap.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of word_to_bit_stream_serializer_if
// Outputs depend on registered state only.
module word_to_bit_stream_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  word_to_bit_stream_serializer_if.slave        bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hb_full;
  logic [WIDTH-1:0] hb_data;
  logic             hb_push, hb_pop;
  logic             transfer;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;

  word_holding_buffer #(.WIDTH(WIDTH)) u_hb (
    .clk    (clk),
    .rst    (rst),
    .push_i (hb_push),
    .pop_i  (hb_pop),
    .data_i (bus.in_data),
    .data_o (hb_data),
    .full_o (hb_full)
  );

  assign transfer   = bus.in_valid && !hb_full;
  assign last_bit   = (cnt_q == LAST_CNT);
  assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sr_q[WIDTH-1:1]};

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned and a latch cannot be inferred.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hb_push = 1'b0;
    hb_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          sr_d    = bus.in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Buffered word wins; in_ready is low then, so no transfer competes.
          if (hb_full) begin
            sr_d   = hb_data;
            hb_pop = 1'b1;
            cnt_d  = '0;
          end else if (transfer) begin
            sr_d  = bus.in_data;
            cnt_d = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (transfer) begin
          hb_push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = !hb_full;
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_bit   = (state_q == SHIFT)
                         ? ((MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0])
                         : IDLE_BIT;
  assign bus.busy      = (state_q == SHIFT) || hb_full;

endmodule
